// File: rtl/ofm_store_pkg.sv
// Shared types and default widths for the OFM write-back stage.
// Imported by the FIFO and the top-level store.
package ofm_store_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_CNT_WIDTH  = 16;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ofm_store_state_t;

endpackage

// File: rtl/ofm_fifo.sv
// Small register-array FIFO with a combinational head.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module ofm_fifo
  import ofm_store_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_WIDTH-1:0]    din,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         cnt;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (cnt == LW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];
  assign level   = cnt;

  // Storage is cleared on reset so the write-data port reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      cnt <= cnt + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/ofm_store.sv
// OFM write-back stage: buffers packed words and streams them
// to sequential SRAM addresses, one job of num_words at a time.
module ofm_store
  import ofm_store_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ADDR_WIDTH-1:0]       base_addr,
  input  logic [CNT_WIDTH-1:0]        num_words,
  input  logic                        ofm_valid,
  input  logic [DATA_WIDTH-1:0]       ofm_data,
  output logic                        mem_wr_en,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [DATA_WIDTH-1:0]       mem_wdata,
  input  logic                        mem_ready,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  ofm_store_state_t state;
  ofm_store_state_t state_nxt;

  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [CNT_WIDTH-1:0]  num_q;
  logic [CNT_WIDTH-1:0]  in_cnt;
  logic [CNT_WIDTH-1:0]  out_cnt;

  logic in_run;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic last_pop;
  logic drop;
  logic take_start;

  assign in_run     = (state == RUN);
  assign take_start = (state == IDLE) && start;

  assign mem_wr_en = in_run && !empty;
  assign pop       = mem_wr_en && mem_ready;
  assign push      = in_run && ofm_valid
                  && (in_cnt < num_q)
                  && (!full || pop);
  assign drop      = in_run && ofm_valid && !push;
  // num_q is at least 1 whenever RUN is entered.
  assign last_pop  = pop
                  && (out_cnt == num_q - CNT_WIDTH'(1));

  assign mem_addr = wr_addr;
  assign busy     = in_run;
  assign done     = (state == DONE);

  ofm_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (ofm_data),
    .dout  (mem_wdata),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (num_words == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_pop) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr  <= '0;
      num_q    <= '0;
      in_cnt   <= '0;
      out_cnt  <= '0;
      overflow <= 1'b0;
    end else if (take_start) begin
      wr_addr  <= base_addr;
      num_q    <= num_words;
      in_cnt   <= '0;
      out_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        in_cnt <= in_cnt + CNT_WIDTH'(1);
      end
      if (pop) begin
        wr_addr <= wr_addr + ADDR_WIDTH'(1);
        out_cnt <= out_cnt + CNT_WIDTH'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: doc/ofm_store.md
# ofm_store

Write-back stage directly downstream of the OFM packing buffer. Accepts the 32-bit packed OFM words emitted on that buffer's one-cycle finish pulse. Holds them in a small FIFO and writes them to sequential addresses of the output feature-map SRAM through a valid/ready write port. One job covers `num_words` words; it is armed by `start` and ends with a one-cycle `done` pulse.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: packed OFM word width.
- `ADDR_WIDTH`, default 16: SRAM word-address width.
- `CNT_WIDTH`, default 16: job word-count width.
- `FIFO_DEPTH`, default 4: FIFO entries, power of two, ≥2.

Ports. One clock; reset is asynchronous and active-high.
- `clk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: job start strobe, sampled in IDLE only.
- `base_addr`, in, ADDR_WIDTH: first write address, latched on accepted `start`.
- `num_words`, in, CNT_WIDTH: words in the job, latched on accepted `start`.
- `ofm_valid`, in, 1: one-cycle word strobe from the packing buffer's finish pulse.
- `ofm_data`, in, DATA_WIDTH: packed word, valid while `ofm_valid`=1.
- `mem_wr_en`, out, 1: write request.
- `mem_addr`, out, ADDR_WIDTH: write address.
- `mem_wdata`, out, DATA_WIDTH: write data, taken from the FIFO head.
- `mem_ready`, in, 1: SRAM accepts the write this cycle.
- `busy`, out, 1: high in RUN.
- `done`, out, 1: one-cycle pulse at job end.
- `overflow`, out, 1: sticky; a word was dropped.
- `fifo_level`, out, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `start`=1 latches `base_addr` into `wr_addr` and `num_words`.
  - Clears `in_cnt`, `out_cnt` and `overflow`.
  - Goes to RUN, or to DONE directly if `num_words`=0.
  - `ofm_valid` in IDLE is ignored and does not set `overflow`.
- RUN:
  - **Push.** Occurs when `ofm_valid`=1 && `in_cnt`<`num_words` && (FIFO not full, or a pop happens in the same cycle). A push increments `in_cnt`.
  - **Dropped word.** `ofm_valid` with FIFO full and no pop, or with `in_cnt`=`num_words`, drops the word and sets `overflow`.
  - **Pop.** `mem_wr_en` = RUN && FIFO not empty, combinational. A pop occurs on `mem_wr_en && mem_ready`.
  - **Per pop.** Increments `wr_addr` (wraps modulo 2^ADDR_WIDTH) and `out_cnt`.
  - `mem_addr`=`wr_addr`; `mem_wdata`=FIFO head. Both are held stable while `mem_wr_en`=1 and `mem_ready`=0.
  - **Exit.** The pop that makes `out_cnt`=`num_words` moves the block to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` outside IDLE is ignored.
- `ofm_data` is stored bit-exact; no byte reordering or masking.

## Timing
- **Reset values.** On `rst`, asynchronously: state IDLE, all counters 0, FIFO empty, `mem_wr_en`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `overflow`=0, `fifo_level`=0.
- **Reset mid-job.** `rst` during RUN aborts the job. All of the above reset values apply, and no `done` pulse is issued.
- **start to busy.** `start` at edge N gives `busy`=1 after N.
- **Word to write request.** A push into an empty FIFO at edge N gives `mem_wr_en`=1 after N.
- **Throughput.** One word per cycle while `mem_ready`=1.
- **Last write to done.** The final pop at edge N gives `done`=1 after N and `busy`=0 in the same cycle.
- **Full FIFO with push and pop.** Both occur; the level stays at FIFO_DEPTH; nothing is dropped.
- **Empty FIFO with push and no `mem_wr_en`.** The level becomes 1; the push is not forwarded combinationally to the write port.

## Structure
- Package `ofm_store_pkg`:
  - state enum `ofm_store_state_t` (IDLE, RUN, DONE);
  - default width localparams.
- Sub-module `ofm_fifo`: synchronous FIFO.
  - Register array with head exposed combinationally.
  - Ports: push, pop, din, dout, full, empty, level.
  - Same clock and reset as the top.
- Top holds the FSM, the counters and the address register.

## Test plan
1. **Single word.** `start`, `base_addr`=0x0100, `num_words`=1; one `ofm_valid` with 0x00A1B2C3; `mem_ready`=1. Expect one write of 0x00A1B2C3 to 0x0100, then `done` one cycle after it.
2. **Back-pressure.** `num_words`=6; words arrive every 3rd cycle; `mem_ready` low for 10 cycles, then high. Expect no drop, `fifo_level` peaks at 4, six writes to 0x0100..0x0105 in order, `overflow`=0.
3. **Overflow.** FIFO_DEPTH=4; `mem_ready`=0; 5 consecutive `ofm_valid`. Expect `fifo_level`=4 and `overflow`=1. The 5th word is never written; the first 4 are written after `mem_ready` rises.
4. **Full FIFO, push and pop together.** FIFO full, `mem_ready`=1, `ofm_valid`=1 in the same cycle. Expect the level to stay at 4 and `overflow` to stay 0.
5. **Boundary jobs.**
   - `num_words`=0: expect `done` one cycle after `start` and no write.
   - `base_addr`=0xFFFF, `num_words`=2: expect writes to 0xFFFF, then 0x0000.
6. **Reset mid-job.** Assert `rst` in RUN with 2 words queued. Expect all outputs 0 and IDLE immediately. A new `start` afterwards runs cleanly.
